// File: rtl/axi_lite_pkg.sv
// Shared defaults for the AXI-Lite command master.
// Widths, read tag count and write credit limit.
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int N_IDS  = 2 ** ID_W;
  localparam int MAX_WR = 8;

endpackage

// File: rtl/axi_lite_id_pool.sv
// Read tag pool: free bitmap, lowest-free encoder and
// per-tag address table.
module axi_lite_id_pool
  import axi_lite_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int IW = ID_W,
  parameter int N  = 2 ** IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  output logic          avail,
  output logic [IW-1:0] alloc_id,
  input  logic          free_en,
  input  logic [IW-1:0] rid,
  output logic          rid_busy,
  output logic [AW-1:0] rid_addr,
  output logic          any_busy
);

  logic [N-1:0]         busy_q, busy_d;
  logic [N-1:0][AW-1:0] tbl_q, tbl_d;

  // Scan downward so the last hit is the lowest index.
  always_comb begin
    avail    = 1'b0;
    alloc_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        avail    = 1'b1;
        alloc_id = IW'(i);
      end
    end
  end

  // Allocation sees busy_q, so a tag freed this cycle is not reused yet.
  always_comb begin
    busy_d = busy_q;
    tbl_d  = tbl_q;
    if (free_en)
      busy_d[rid] = 1'b0;
    if (alloc_en) begin
      busy_d[alloc_id] = 1'b1;
      tbl_d[alloc_id]  = alloc_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      tbl_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tbl_q  <= tbl_d;
    end
  end

  assign rid_busy = busy_q[rid];
  assign rid_addr = tbl_q[rid];
  assign any_busy = |busy_q;

endmodule

// File: rtl/axi_lite_master.sv
// AXI-Lite master: one command at a time onto AR or AW/W,
// out-of-order tagged reads, credit-limited writes.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH         = ADDR_W,
  parameter int DATA_WIDTH         = DATA_W,
  parameter int ID_WIDTH           = ID_W,
  parameter int MAX_WR_OUTSTANDING = MAX_WR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [ID_WIDTH-1:0]   arid,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [ID_WIDTH-1:0]   rid,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ID_WIDTH-1:0]   rsp_id,
  input  logic                  rsp_ready,
  output logic                  wr_done,
  output logic                  busy,
  output logic                  err
);

  localparam int CW = $clog2(MAX_WR_OUTSTANDING + 1);

  logic                  arvalid_q, arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic                  awvalid_q, awvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                  wr_done_q, wr_done_d;
  logic                  err_q, err_d;
  logic                  bready_q;

  logic                  idle, wr_room, rd_acc, wr_acc;
  logic                  b_hs, b_ok, r_hs, r_ok;
  logic                  id_avail, rid_busy, any_busy;
  logic [ID_WIDTH-1:0]   alloc_id;
  logic [ADDR_WIDTH-1:0] rid_addr;

  axi_lite_id_pool #(
    .AW (ADDR_WIDTH),
    .IW (ID_WIDTH)
  ) u_pool (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (rd_acc),
    .alloc_addr (cmd_addr),
    .avail      (id_avail),
    .alloc_id   (alloc_id),
    .free_en    (r_ok),
    .rid        (rid),
    .rid_busy   (rid_busy),
    .rid_addr   (rid_addr),
    .any_busy   (any_busy)
  );

  always_comb begin
    idle      = !arvalid_q && !awvalid_q && !wvalid_q;
    wr_room   = wr_cnt_q < CW'(MAX_WR_OUTSTANDING);
    cmd_ready = idle && (cmd_write ? wr_room : id_avail);
    rd_acc    = cmd_valid && cmd_ready && !cmd_write;
    wr_acc    = cmd_valid && cmd_ready && cmd_write;
    b_hs      = bvalid && bready_q;
    b_ok      = b_hs && (wr_cnt_q != '0);
    rready    = !rsp_valid_q || rsp_ready;
    r_hs      = rvalid && rready;
    r_ok      = r_hs && rid_busy;
  end

  always_comb begin
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arid_d      = arid_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_id_d    = rsp_id_q;
    wr_cnt_d    = wr_cnt_q;
    wr_done_d   = b_hs;
    err_d       = err_q;

    if (rd_acc) begin
      arvalid_d = 1'b1;
      araddr_d  = cmd_addr;
      arid_d    = alloc_id;
    end else if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end

    if (wr_acc) begin
      awvalid_d = 1'b1;
      awaddr_d  = cmd_addr;
      wvalid_d  = 1'b1;
      wdata_d   = cmd_wdata;
    end else begin
      if (awvalid_q && awready) awvalid_d = 1'b0;
      if (wvalid_q && wready)   wvalid_d  = 1'b0;
    end

    if (wr_acc && !b_ok)
      wr_cnt_d = wr_cnt_q + CW'(1);
    else if (!wr_acc && b_ok)
      wr_cnt_d = wr_cnt_q - CW'(1);

    if (b_hs && !b_ok)
      err_d = 1'b1;

    // Beats for tags we never issued are dropped.
    if (r_ok) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rdata;
      rsp_addr_d  = rid_addr;
      rsp_id_d    = rid;
    end else begin
      if (r_hs) err_d = 1'b1;
      if (rsp_ready) rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arid_q      <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
      rsp_id_q    <= '0;
      wr_cnt_q    <= '0;
      wr_done_q   <= 1'b0;
      err_q       <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arid_q      <= arid_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_id_q    <= rsp_id_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_done_q   <= wr_done_d;
      err_q       <= err_d;
      bready_q    <= 1'b1;
    end
  end

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arid      = arid_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign bready    = bready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_id    = rsp_id_q;
  assign wr_done   = wr_done_q;
  assign err       = err_q;
  assign busy      = (wr_cnt_q != '0) || any_busy || !idle;

endmodule
